serial_link_rx: RTL and testbench
=================================

# serial_link_rx

Receiving end of the three-wire serial link (`transmission`, `clock`, `data`) that `top` drives. The block oversamples the link with the local system clock and deserializes MSB-first words. It presents each complete word on a one-deep valid/ready holding register, and flags malformed frames and overruns. It sits on the consumer board, between the link pins and the pulse-timing processing logic.

## Interface
Parameters:
- WORD_BITS, 32, payload bits per frame; must be ≥2.
- COUNT_BITS, 16, width of the delivered-frame counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- transmission  in  1  link frame enable; asynchronous to clk.
- clock  in  1  link bit clock; data is valid on its rising edge; asynchronous to clk.
- data  in  1  link serial data, MSB first; asynchronous to clk.
- rx_data  out  WORD_BITS  received word; held while rx_valid is high.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data on a cycle where rx_valid and rx_ready are both high.
- frame_err  out  1  one-cycle pulse when a frame ends with the wrong bit count.
- overrun  out  1  one-cycle pulse when a good word is dropped because the holding register is full.
- frame_count  out  COUNT_BITS  number of words delivered to the holding register; wraps.

## Operation
- Input conditioning:
  - `transmission`, `clock` and `data` each pass through an identical 2-flop synchronizer, so all three stay aligned.
  - A third register on sync'd `transmission` and sync'd `clock` gives rise/fall detection.
- Reset: asynchronous to all of the following values.
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, frame_count=0.
  - Internal: synchronizers=0, shift register=0, bit counter=0, too_long=0, state=ARM.
- States:
  - ARM: wait for sync'd `transmission` low, then go to IDLE. This prevents joining a frame mid-stream after reset.
  - IDLE: sync'd `transmission` rising → RECV, clear shift register, bit counter and too_long. `clock` edges are ignored.
  - RECV, on sync'd `clock` rising:
    - If bit counter < WORD_BITS: shift register ← {shift[WORD_BITS-2:0], sync data}, counter+1.
    - Otherwise: set too_long; no shift.
  - RECV, on sync'd `transmission` falling → IDLE:
    - Good frame (counter==WORD_BITS and !too_long) → deliver the shift register.
    - Anything else → frame_err pulse; no delivery; frame_count unchanged.
- Simultaneous `clock` rise and `transmission` fall in the same sync cycle: the bit is shifted and counted first. The end-of-frame check includes that bit.
- Delivery:
  - If rx_valid=0, or rx_valid&rx_ready in the same cycle: load rx_data, rx_valid=1, frame_count+1.
  - If rx_valid=1 and rx_ready=0: pulse overrun, drop the new word, keep rx_data, frame_count unchanged.
- Accept without a new word: rx_valid&rx_ready → rx_valid=0 next cycle; rx_data keeps its last value.
- frame_count wraps from 2^COUNT_BITS-1 to 0.
- Bit counter width is clog2(WORD_BITS+1). It saturates at WORD_BITS; too_long records any excess.

## Timing
- Latencies:
  - Link level first sampled at clk edge k → visible in the synchronizer after edge k+1.
  - `transmission` fall sampled at edge k → rx_valid, rx_data, frame_count (or frame_err/overrun) update at edge k+2.
  - `clock` rise sampled at edge k → bit shifted at edge k+2, using `data` sampled at edge k.
- Link requirements:
  - `clock` high ≥3 clk periods and low ≥3 clk periods.
  - `data` stable ≥3 clk periods before and ≥1 clk period after each `clock` rise.
  - `transmission` rises ≥3 clk periods before the first `clock` rise and falls ≥3 clk periods after the last one.
  - Frames are separated by ≥3 clk periods of `transmission` low.
- Pulses: frame_err and overrun are high for exactly one clk cycle per event. They never assert in the same cycle.
- Reset mid-frame: everything clears immediately. The rest of the frame is ignored silently (ARM) with no frame_err. The next full frame is received normally.
- rx_ready has no effect while rx_valid=0.

## Test plan
- After reset, send one 32-bit frame 0xDEADBEEF with rx_ready=1 → rx_valid rises 2 edges after `transmission` low is sampled; rx_data=0xDEADBEEF; frame_count=1; next cycle rx_valid=0.
- Send 31-bit and 33-bit frames → exactly one frame_err pulse each; rx_valid stays 0; frame_count stays 0.
- With rx_ready=0, send 0x00000001 then 0xFFFFFFFF → overrun pulses once; rx_data=0x00000001; frame_count=1. Raise rx_ready for one cycle → rx_valid=0.
- Hold rx_valid=1 and raise rx_ready in the same cycle a new word 0x12345678 arrives → rx_data=0x12345678; rx_valid stays 1; no overrun; frame_count increments.
- Assert rst after 10 bits of a frame, release it, and finish that frame → no rx_valid and no frame_err. A following frame 0xA5A5A5A5 is received correctly.
- Drive the last `clock` rise and the `transmission` fall in the same clk cycle → the 32nd bit is counted and the word is delivered without frame_err.

Source files
------------

// File: rtl/serial_link_rx.sv
// Receiver for the three-wire serial link: oversamples transmission/clock/data,
// deserializes MSB-first words into a one-deep valid/ready holding register.
module serial_link_rx #(
  parameter int WORD_BITS  = 32,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  transmission,
  input  logic                  clock,
  input  logic                  data,
  output logic [WORD_BITS-1:0]  rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [COUNT_BITS-1:0] frame_count
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_BITS);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RECV = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    trans_s1_r, trans_s2_r, trans_s3_r;
  logic                    clock_s1_r, clock_s2_r, clock_s3_r;
  logic                    data_s1_r, data_s2_r;
  logic [WORD_BITS-1:0]    shift_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    too_long_r;
  logic [1:0]              arm_cnt_r;
  logic [WORD_BITS-1:0]    rx_data_r;
  logic                    rx_valid_r;
  logic                    frame_err_r;
  logic                    overrun_r;
  logic [COUNT_BITS-1:0]   frame_count_r;

  logic                    trans_rise_s, trans_fall_s, clk_rise_s;
  logic [WORD_BITS-1:0]    shift_nxt_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    too_long_nxt_s;
  logic                    good_s;

  // Identical synchronizer depth on all three link wires keeps them aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_s1_r <= 1'b0;
      trans_s2_r <= 1'b0;
      trans_s3_r <= 1'b0;
      clock_s1_r <= 1'b0;
      clock_s2_r <= 1'b0;
      clock_s3_r <= 1'b0;
      data_s1_r  <= 1'b0;
      data_s2_r  <= 1'b0;
    end else begin
      trans_s1_r <= transmission;
      trans_s2_r <= trans_s1_r;
      trans_s3_r <= trans_s2_r;
      clock_s1_r <= clock;
      clock_s2_r <= clock_s1_r;
      clock_s3_r <= clock_s2_r;
      data_s1_r  <= data;
      data_s2_r  <= data_s1_r;
    end
  end

  assign trans_rise_s = trans_s2_r & ~trans_s3_r;
  assign trans_fall_s = ~trans_s2_r & trans_s3_r;
  assign clk_rise_s   = clock_s2_r & ~clock_s3_r;

  // Next shift/count state; the end-of-frame check uses it so a bit clocked
  // in the same cycle as the frame end is counted.
  always_comb begin
    shift_nxt_s    = shift_r;
    cnt_nxt_s      = cnt_r;
    too_long_nxt_s = too_long_r;
    if (clk_rise_s) begin
      if (cnt_r < WORD_CNT) begin
        shift_nxt_s = {shift_r[WORD_BITS-2:0], data_s2_r};
        cnt_nxt_s   = cnt_r + CNT_W'(1);
      end else begin
        too_long_nxt_s = 1'b1;
      end
    end else begin
      shift_nxt_s = shift_r;
    end
    good_s = (cnt_nxt_s == WORD_CNT) && !too_long_nxt_s;
  end

  // Frame FSM with holding register and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_ARM;
      shift_r       <= '0;
      cnt_r         <= '0;
      too_long_r    <= 1'b0;
      arm_cnt_r     <= 2'd0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_r     <= 1'b0;
      frame_count_r <= '0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end
      case (state_r)
        ST_ARM: begin
          // Synchronizer contents are only trusted once refilled after reset.
          if (arm_cnt_r != 2'd3) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
          end else if (!trans_s2_r) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (trans_rise_s) begin
            state_r    <= ST_RECV;
            shift_r    <= '0;
            cnt_r      <= '0;
            too_long_r <= 1'b0;
          end
        end
        ST_RECV: begin
          shift_r    <= shift_nxt_s;
          cnt_r      <= cnt_nxt_s;
          too_long_r <= too_long_nxt_s;
          if (trans_fall_s) begin
            state_r <= ST_IDLE;
            if (!good_s) begin
              frame_err_r <= 1'b1;
            end else if (!rx_valid_r || rx_ready) begin
              rx_data_r     <= shift_nxt_s;
              rx_valid_r    <= 1'b1;
              frame_count_r <= frame_count_r + COUNT_BITS'(1);
            end else begin
              overrun_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_ARM;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign frame_err   = frame_err_r;
  assign overrun     = overrun_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_serial_link_rx.sv
// Directed bench for serial_link_rx: drives link frames and checks delivery,
// frame errors, overruns, mid-frame reset and coincident clock/frame edges.
module tb_serial_link_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        transmission = 1'b0;
  logic        clock = 1'b0;
  logic        data = 1'b0;
  logic        rx_ready = 1'b1;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int vld_rise = 0;
  logic vld_d = 1'b0;
  int e0, v0, o0;

  serial_link_rx #(.WORD_BITS(32), .COUNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock), .data(data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Event monitor for one-cycle pulses and rx_valid rising edges.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (rx_valid && !vld_d) vld_rise++;
    vld_d = rx_valid;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic frame_start();
    transmission = 1'b1;
    cyc(4);
  endtask

  task automatic send_bit(input logic b);
    data = b;
    cyc(4);
    clock = 1'b1;
    cyc(4);
    clock = 1'b0;
    cyc(4);
  endtask

  // Ends with transmission driven low just after a clk edge.
  task automatic send_frame(input logic [63:0] w, input int nbits, input bit same_edge);
    frame_start();
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == 0 && same_edge) begin
        data = w[i];
        cyc(4);
        clock = 1'b1;
        transmission = 1'b0;
      end else begin
        send_bit(w[i]);
      end
    end
    if (same_edge) begin
      cyc(4);
      clock = 1'b0;
    end else begin
      transmission = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_count", frame_count, 0);
    check_eq("rst_err", frame_err, 0);
    check_eq("rst_ovr", overrun, 0);
    rst = 1'b0;
    cyc(6);

    // Basic delivery and latency
    send_frame(64'hDEADBEEF, 32, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_pre", rx_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_valid", rx_valid, 1);
    check_eq("t1_data", rx_data, 32'hDEADBEEF);
    check_eq("t1_count", frame_count, 1);
    @(negedge clk);
    check_eq("t1_accept", rx_valid, 0);
    check_eq("t1_hold", rx_data, 32'hDEADBEEF);
    cyc(8);

    // Short and long frames
    e0 = err_cnt;
    send_frame(64'h2AAAAAAA, 31, 1'b0);
    cyc(8);
    check_eq("short_err", err_cnt - e0, 1);
    send_frame(64'h1_5555_5555, 33, 1'b0);
    cyc(8);
    check_eq("long_err", err_cnt - e0, 2);
    check_eq("bad_valid", rx_valid, 0);
    check_eq("bad_count", frame_count, 1);

    // Overrun
    rx_ready = 1'b0;
    o0 = ov_cnt;
    send_frame(64'h00000001, 32, 1'b0);
    cyc(8);
    send_frame(64'hFFFFFFFF, 32, 1'b0);
    cyc(8);
    check_eq("ovr_pulses", ov_cnt - o0, 1);
    check_eq("ovr_valid", rx_valid, 1);
    check_eq("ovr_data", rx_data, 32'h00000001);
    check_eq("ovr_count", frame_count, 2);
    check_eq("ovr_noerr", err_cnt - e0, 2);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    @(negedge clk);
    check_eq("ovr_drain", rx_valid, 0);

    // Accept and reload in the same cycle
    send_frame(64'h0BADF00D, 32, 1'b0);
    cyc(8);
    check_eq("fill_data", rx_data, 32'h0BADF00D);
    check_eq("fill_count", frame_count, 3);
    o0 = ov_cnt;
    send_frame(64'h12345678, 32, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rx_ready = 1'b1;
    @(posedge clk);
    #2 rx_ready = 1'b0;
    @(negedge clk);
    check_eq("swap_valid", rx_valid, 1);
    check_eq("swap_data", rx_data, 32'h12345678);
    check_eq("swap_count", frame_count, 4);
    check_eq("swap_noovr", ov_cnt - o0, 0);
    rx_ready = 1'b1;
    cyc(8);

    // Reset in the middle of a frame
    e0 = err_cnt;
    v0 = vld_rise;
    frame_start();
    for (int i = 31; i >= 22; i--) send_bit(1'b1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_count", frame_count, 0);
    for (int i = 21; i >= 0; i--) send_bit(1'b0);
    transmission = 1'b0;
    cyc(8);
    check_eq("mid_rst_noerr", err_cnt - e0, 0);
    check_eq("mid_rst_novalid", vld_rise - v0, 0);
    send_frame(64'hA5A5A5A5, 32, 1'b0);
    cyc(8);
    check_eq("after_rst_vld", vld_rise - v0, 1);
    check_eq("after_rst_data", rx_data, 32'hA5A5A5A5);
    check_eq("after_rst_count", frame_count, 1);

    // Last clock rise coincident with transmission fall
    send_frame(64'hCAFEF00D, 32, 1'b1);
    cyc(8);
    check_eq("same_data", rx_data, 32'hCAFEF00D);
    check_eq("same_count", frame_count, 2);
    check_eq("same_noerr", err_cnt - e0, 0);
    check_eq("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
